// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: end-of-count modes and the run/halt state.
package counter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // The reserved encoding 2'b11 behaves as WRAP.
  function automatic mode_t decode_mode(input logic [MODE_W-1:0] m);
    if (m == MODE_SAT)          return MODE_SAT;
    else if (m == MODE_ONESHOT) return MODE_ONESHOT;
    else                        return MODE_WRAP;
  endfunction

endpackage

// File: rtl/cnt_tc_detect.sv
// Terminal-count detection shared by the step logic and the CarryOut output.
module cnt_tc_detect #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             at_top_o,
  output logic             at_bot_o
);

  // ">=" rather than "==" so a limit lowered below the count still terminates.
  assign at_top_o = (cnt_i >= limit_i);
  assign at_bot_o = (cnt_i == '0);

endmodule

// File: rtl/updn_counter_mod.sv
// Loadable up/down counter with programmable limit, wrap/saturate/one-shot modes,
// compare match, sticky wrap flag and a cascadable terminal-count carry.
module updn_counter_mod
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                RESn,
  input  logic                EN,
  input  logic                PL,
  input  logic [WIDTH-1:0]    di,
  input  logic                INC,
  input  logic                DEC,
  input  logic                CarryIn,
  input  logic [MODE_W-1:0]   mode,
  input  logic [WIDTH-1:0]    limit,
  input  logic [WIDTH-1:0]    cmp,
  output logic [WIDTH-1:0]    dout,
  output logic                CarryOut,
  output logic                match,
  output logic                wrapped,
  output logic                done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wrapped_q, wrapped_d;
  state_t           state_q, state_d;

  logic  at_top, at_bot;
  logic  load, step;
  mode_t mode_s;

  cnt_tc_detect #(.WIDTH(WIDTH)) u_tc (
    .cnt_i    (dout_q),
    .limit_i  (limit),
    .at_top_o (at_top),
    .at_bot_o (at_bot)
  );

  assign mode_s = decode_mode(mode);
  assign load   = EN & PL;
  assign step   = EN & ~PL & (INC ^ DEC) & ~CarryIn & (state_q == ST_RUN);

  always_comb begin
    dout_d    = dout_q;
    wrapped_d = wrapped_q;
    state_d   = state_q;
    if (load) begin
      dout_d    = (di > limit) ? limit : di;
      wrapped_d = 1'b0;
      state_d   = ST_RUN;
    end else if (step && INC) begin
      if (!at_top) begin
        dout_d = dout_q + ONE;
      end else if (mode_s == MODE_SAT) begin
        dout_d = limit;
      end else if (mode_s == MODE_ONESHOT) begin
        dout_d  = limit;
        state_d = ST_HALT;
      end else begin
        dout_d    = '0;
        wrapped_d = 1'b1;
      end
    end else if (step) begin
      if (!at_bot) begin
        dout_d = dout_q - ONE;
      end else if (mode_s == MODE_ONESHOT) begin
        state_d = ST_HALT;
      end else if (mode_s == MODE_WRAP) begin
        dout_d    = limit;
        wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RESn) begin
      dout_q    <= RST_VAL;
      wrapped_q <= 1'b0;
      state_q   <= ST_RUN;
    end else begin
      dout_q    <= dout_d;
      wrapped_q <= wrapped_d;
      state_q   <= state_d;
    end
  end

  // Carry is combinational so a cascaded upper stage steps on the same edge.
  assign CarryOut = RESn & step & ((INC & at_top) | (DEC & at_bot));
  assign match    = (dout_q == cmp);
  assign dout     = dout_q;
  assign wrapped  = wrapped_q;
  assign done     = (state_q == ST_HALT);

endmodule

// File: tb/tb_updn_counter_mod.sv
// Scoreboard bench: an 8-bit counter against an integer model, plus a two-stage
// 4-bit cascade modelled as a single 8-bit modulo-256 count.
module tb_updn_counter_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_rn, s_en, s_pl, s_inc, s_dec, s_cin;
  logic [1:0] s_mode;
  logic [7:0] s_di, s_lim, s_cmp;
  logic [7:0] dout;
  logic       co, mt, wr, dn;

  logic       c_pl, c_inc, c_dec, c_cin, hi_cin;
  logic [3:0] c_di_lo, c_di_hi;
  logic [3:0] lo_dout, hi_dout;
  logic       lo_co, hi_co, lo_mt, hi_mt, lo_wr, hi_wr, lo_dn, hi_dn;

  updn_counter_mod #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .RESn(s_rn), .EN(s_en), .PL(s_pl), .di(s_di), .INC(s_inc), .DEC(s_dec),
    .CarryIn(s_cin), .mode(s_mode), .limit(s_lim), .cmp(s_cmp),
    .dout(dout), .CarryOut(co), .match(mt), .wrapped(wr), .done(dn)
  );

  assign hi_cin = ~lo_co;

  updn_counter_mod #(.WIDTH(4), .RST_VAL(4'h0)) u_lo (
    .clk(clk), .RESn(s_rn), .EN(s_en), .PL(c_pl), .di(c_di_lo), .INC(c_inc), .DEC(c_dec),
    .CarryIn(c_cin), .mode(2'b00), .limit(4'hF), .cmp(4'h0),
    .dout(lo_dout), .CarryOut(lo_co), .match(lo_mt), .wrapped(lo_wr), .done(lo_dn)
  );

  updn_counter_mod #(.WIDTH(4), .RST_VAL(4'h0)) u_hi (
    .clk(clk), .RESn(s_rn), .EN(s_en), .PL(c_pl), .di(c_di_hi), .INC(c_inc), .DEC(c_dec),
    .CarryIn(hi_cin), .mode(2'b00), .limit(4'hF), .cmp(4'h0),
    .dout(hi_dout), .CarryOut(hi_co), .match(hi_mt), .wrapped(hi_wr), .done(hi_dn)
  );

  typedef struct {
    int         cyc;
    logic [7:0] dout;
    logic       wr;
    logic       dn;
    logic       co;
    logic       mt;
    logic [7:0] cv;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference state: plain integers for the main counter, one 8-bit value for the cascade.
  int m_d, m_wr, m_halt, m_v;

  // Staged cascade controls, applied together with the main inputs.
  logic       t_cpl, t_cinc, t_cdec, t_ccin;
  logic [7:0] t_cdi;
  logic [1:0] t_mode;
  logic [7:0] t_lim, t_cmp;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp, input int c);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
    end
  endtask

  // Apply one cycle of stimulus just after a rising edge, record what the DUT must
  // show before the next edge, then advance the model across that edge.
  task automatic go(input logic rn, input logic en, input logic pl, input logic inc,
                    input logic dec, input logic cin, input logic [7:0] di);
    exp_t e;
    int   lim;
    @(posedge clk);
    #1;
    cyc++;
    s_rn = rn; s_en = en; s_pl = pl; s_inc = inc; s_dec = dec; s_cin = cin; s_di = di;
    s_mode = t_mode; s_lim = t_lim; s_cmp = t_cmp;
    c_pl = t_cpl; c_inc = t_cinc; c_dec = t_cdec; c_cin = t_ccin;
    c_di_lo = t_cdi[3:0]; c_di_hi = t_cdi[7:4];
    lim = int'(t_lim);

    e.cyc  = cyc;
    e.dout = m_d[7:0];
    e.wr   = (m_wr != 0);
    e.dn   = (m_halt != 0);
    e.co   = rn && en && !pl && !cin && (m_halt == 0) &&
             ((inc && !dec && m_d >= lim) || (dec && !inc && m_d == 0));
    e.mt   = (m_d == int'(t_cmp));
    e.cv   = m_v[7:0];
    sbq.push_back(e);

    if (!rn) begin
      m_d = 0; m_wr = 0; m_halt = 0;
    end else if (!en) begin
      m_d = m_d;
    end else if (pl) begin
      m_d = (int'(di) < lim) ? int'(di) : lim;
      m_wr = 0; m_halt = 0;
    end else if (inc != dec && !cin && m_halt == 0) begin
      if (inc) begin
        if (m_d < lim) m_d = m_d + 1;
        else if (t_mode == 2'd1) m_d = lim;
        else if (t_mode == 2'd2) begin m_d = lim; m_halt = 1; end
        else begin m_d = 0; m_wr = 1; end
      end else begin
        if (m_d > 0) m_d = m_d - 1;
        else if (t_mode == 2'd2) m_halt = 1;
        else if (t_mode != 2'd1) begin m_d = lim; m_wr = 1; end
      end
    end

    if (!rn) m_v = 0;
    else if (en && t_cpl) m_v = int'(t_cdi);
    else if (en && (t_cinc != t_cdec) && !t_ccin) m_v = t_cinc ? (m_v + 1) % 256 : (m_v + 255) % 256;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("dout",     dout,                 e.dout,          e.cyc);
        chk("wrapped",  {7'd0, wr},           {7'd0, e.wr},    e.cyc);
        chk("done",     {7'd0, dn},           {7'd0, e.dn},    e.cyc);
        chk("CarryOut", {7'd0, co},           {7'd0, e.co},    e.cyc);
        chk("match",    {7'd0, mt},           {7'd0, e.mt},    e.cyc);
        chk("cascade",  {hi_dout, lo_dout},   e.cv,            e.cyc);
      end
    end
  end

  initial begin : stim
    s_rn = 1'b0; s_en = 1'b1; s_pl = 1'b0; s_inc = 1'b0; s_dec = 1'b0; s_cin = 1'b0;
    s_mode = 2'd0; s_lim = 8'hFF; s_cmp = 8'h00; s_di = 8'h00;
    c_pl = 1'b0; c_inc = 1'b0; c_dec = 1'b0; c_cin = 1'b0; c_di_lo = 4'h0; c_di_hi = 4'h0;
    t_cpl = 1'b0; t_cinc = 1'b0; t_cdec = 1'b0; t_ccin = 1'b0; t_cdi = 8'h00;
    t_mode = 2'd0; t_lim = 8'hFF; t_cmp = 8'h00;
    m_d = 0; m_wr = 0; m_halt = 0; m_v = 0;

    // Reset held, then clamped load.
    go(0, 1, 0, 0, 0, 0, 8'h00);
    t_lim = 8'h10;
    go(1, 1, 1, 0, 0, 0, 8'h20);
    go(1, 1, 0, 0, 0, 0, 8'h00);

    // WRAP up through limit 9.
    t_mode = 2'd0; t_lim = 8'd9;
    go(1, 1, 1, 0, 0, 0, 8'd7);
    repeat (4) go(1, 1, 0, 1, 0, 0, 8'h00);
    go(1, 1, 0, 0, 0, 0, 8'h00);

    // SAT down, then the hold conditions.
    t_mode = 2'd1;
    go(1, 1, 1, 0, 0, 0, 8'd2);
    repeat (4) go(1, 1, 0, 0, 1, 0, 8'h00);
    go(1, 1, 1, 0, 0, 0, 8'd5);
    go(1, 1, 0, 0, 1, 0, 8'h00);
    go(1, 1, 0, 0, 1, 1, 8'h00);
    go(1, 0, 0, 0, 1, 0, 8'h00);
    go(1, 1, 0, 1, 1, 0, 8'h00);
    go(1, 1, 0, 0, 0, 0, 8'h00);

    // ONESHOT to limit 3, halt, reload resumes.
    t_mode = 2'd2; t_lim = 8'd3;
    go(1, 1, 1, 0, 0, 0, 8'd0);
    repeat (6) go(1, 1, 0, 1, 0, 0, 8'h00);
    t_mode = 2'd0;
    go(1, 1, 0, 1, 0, 0, 8'h00);
    t_mode = 2'd2;
    go(1, 1, 1, 0, 0, 0, 8'd0);
    repeat (2) go(1, 1, 0, 1, 0, 0, 8'h00);
    go(1, 1, 0, 0, 0, 0, 8'h00);

    // Cascade: lower 15, upper 2, one increment carries across.
    t_cpl = 1'b1; t_cdi = 8'h2F;
    go(1, 1, 0, 0, 0, 0, 8'h00);
    t_cpl = 1'b0; t_cinc = 1'b1;
    go(1, 1, 0, 0, 0, 0, 8'h00);
    t_cinc = 1'b0;
    go(1, 1, 0, 0, 0, 0, 8'h00);

    // Compare match while counting, then reset together with a load.
    t_mode = 2'd0; t_lim = 8'd9; t_cmp = 8'd5;
    go(1, 1, 1, 0, 0, 0, 8'd3);
    repeat (4) go(1, 1, 0, 1, 0, 0, 8'h00);
    go(0, 1, 1, 0, 0, 0, 8'd7);
    go(1, 1, 0, 0, 0, 0, 8'h00);

    // Randomized traffic, including live limit changes and mode changes in HALT.
    for (int i = 0; i < 600; i++) begin
      logic rn, en, pl, inc, dec, cin;
      logic [7:0] di;
      rn  = ($urandom_range(0, 40) != 0);
      en  = ($urandom_range(0, 7) != 0);
      pl  = ($urandom_range(0, 11) == 0);
      inc = $urandom_range(0, 1);
      dec = $urandom_range(0, 1);
      cin = ($urandom_range(0, 4) == 0);
      di  = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) t_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        t_lim = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 12));
      t_cmp  = 8'($urandom_range(0, 12));
      t_cpl  = ($urandom_range(0, 19) == 0);
      t_cdi  = 8'($urandom_range(0, 255));
      t_cinc = $urandom_range(0, 1);
      t_cdec = $urandom_range(0, 1);
      t_ccin = ($urandom_range(0, 5) == 0);
      go(rn, en, pl, inc, dec, cin, di);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
